bg_scroll_fetch: RTL

BG_SCROLL_FETCH -- requirements
Module: bg_scroll_fetch

---
 rtl/bg_scroll_fetch_pkg.sv | 48 ++++
 rtl/bg_scroll_fetch_pixel_pipe.sv | 76 +++++++
 rtl/bg_scroll_fetch.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bg_scroll_fetch_pkg.sv
// ---------------------------------------------------------------------------
// bg_scroll_fetch_pkg
// Shared types and constants for the scrolling background fetch block:
//   dir_t       - move direction encoding as seen on move_dir
//   state_t     - scroll controller states
//   PALETTE     - 16-entry, 12-bit {R,G,B} colour table
//   WALL_IDX    - palette index that marks a blocking map tile
//   *_DEF       - default map / viewport / step geometry
// ---------------------------------------------------------------------------
package bg_scroll_fetch_pkg;

  // Map is square and a power of two so that every coordinate is 9 bits.
  localparam int MAP_W_DEF  = 512;
  localparam int VIEW_W_DEF = 320;   // 640 screen pixels at 2x scale
  localparam int VIEW_H_DEF = 240;   // 480 screen pixels at 2x scale
  localparam int STEP_DEF   = 16;    // one tile per move
  localparam int COORD_W    = 9;

  localparam logic [3:0] WALL_IDX = 4'hF;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROBE,
    ST_CHECK,
    ST_SCROLL,
    ST_DONE
  } state_t;

  // Ascending range so PALETTE[0] is the leftmost entry below.
  localparam logic [0:15][11:0] PALETTE = {
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  function automatic logic [11:0] palette_lookup(input logic [3:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/bg_scroll_fetch_pixel_pipe.sv
// ---------------------------------------------------------------------------
// bg_pixel_pipe
// Two-stage display fetch pipeline.
//   Stage 1: rom_address_a <= {cam_y + DrawY/2, cam_x + DrawX/2} (9-bit wrap)
//   Stage 2: {red,green,blue} <= palette[rom_q_a], or 0 outside the visible
//            region (blank delayed to line up with the ROM data).
// Ports:
//   vga_clk, Reset        clock, synchronous active-high reset
//   cam_x, cam_y          camera origin in map pixels
//   DrawX, DrawY, blank   current screen pixel and display enable
//   rom_address_a/rom_q_a display ROM port (one-cycle read latency)
//   red, green, blue      registered pixel colour
// ---------------------------------------------------------------------------
module bg_pixel_pipe
  import bg_scroll_fetch_pkg::*;
(
  input  logic         vga_clk,
  input  logic         Reset,
  input  logic [8:0]   cam_x,
  input  logic [8:0]   cam_y,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  input  logic         blank,
  input  logic [3:0]   rom_q_a,
  output logic [17:0]  rom_address_a,
  output logic [3:0]   red,
  output logic [3:0]   green,
  output logic [3:0]   blue
);

  logic [17:0] addr_a_q, addr_a_d;
  logic        blank_dly1_q, blank_dly1_d;
  logic        blank_dly2_q, blank_dly2_d;
  logic [11:0] rgb_q, rgb_d;
  logic [8:0]  map_x, map_y;

  // Screen pixels are doubled, so the LSBs never reach the map address.
  logic unused_lsbs;
  assign unused_lsbs = DrawX[0] ^ DrawY[0];

  // NOTE: every signal written in always_comb gets a value on every path;
  // a branch that leaves one unassigned would infer a latch.
  always_comb begin
    map_x        = cam_x + DrawX[9:1];
    map_y        = cam_y + DrawY[9:1];
    addr_a_d     = {map_y, map_x};
    blank_dly1_d = blank;
    blank_dly2_d = blank_dly1_q;
    // blank_dly2_q belongs to the same pixel whose ROM data is on rom_q_a.
    rgb_d        = blank_dly2_q ? palette_lookup(rom_q_a) : 12'h000;
  end

  // NOTE: the palette is a constant table rather than storage, so there is
  // nothing to reset there; only the pipeline registers are cleared.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      addr_a_q     <= '0;
      blank_dly1_q <= 1'b0;
      blank_dly2_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      addr_a_q     <= addr_a_d;
      blank_dly1_q <= blank_dly1_d;
      blank_dly2_q <= blank_dly2_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rom_address_a = addr_a_q;
  assign red           = rgb_q[11:8];
  assign green         = rgb_q[7:4];
  assign blue          = rgb_q[3:0];

endmodule

// File: rtl/bg_scroll_fetch.sv
// ---------------------------------------------------------------------------
// bg_scroll_fetch
// Scrolling background renderer with tile-step camera moves.
// A move request is bounds-checked against the map, then the tile the player
// would step onto is probed through ROM port B; if it is not a wall the
// camera glides one pixel per frame_tick until it has moved STEP pixels.
// Ports:
//   vga_clk, Reset            clock, synchronous active-high reset
//   DrawX, DrawY, blank       current screen pixel and display enable
//   frame_tick                one-cycle pulse at start of vertical blank
//   move_req, move_dir        move request (level) and direction (dir_t)
//   move_done, move_ok        completion pulse and its result
//   busy                      controller is not idle
//   rom_address_a, rom_q_a    display ROM port
//   rom_address_b, rom_q_b    collision probe ROM port
//   red, green, blue          pixel colour
//   cam_x, cam_y              camera origin in map pixels
// ---------------------------------------------------------------------------
module bg_scroll_fetch
  import bg_scroll_fetch_pkg::*;
#(
  parameter int MAP_W  = MAP_W_DEF,
  parameter int VIEW_W = VIEW_W_DEF,
  parameter int VIEW_H = VIEW_H_DEF,
  parameter int STEP   = STEP_DEF
) (
  input  logic         vga_clk,
  input  logic         Reset,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  input  logic         blank,
  input  logic         frame_tick,
  input  logic         move_req,
  input  logic [1:0]   move_dir,
  output logic         move_done,
  output logic         move_ok,
  output logic         busy,
  output logic [17:0]  rom_address_a,
  input  logic [3:0]   rom_q_a,
  output logic [17:0]  rom_address_b,
  input  logic [3:0]   rom_q_b,
  output logic [3:0]   red,
  output logic [3:0]   green,
  output logic [3:0]   blue,
  output logic [8:0]   cam_x,
  output logic [8:0]   cam_y
);

  // Legal camera range; 10 bits so the bounds arithmetic cannot wrap.
  localparam logic [9:0] CAM_X_MAX = 10'(MAP_W - VIEW_W);
  localparam logic [9:0] CAM_Y_MAX = 10'(MAP_W - VIEW_H);
  localparam logic [9:0] STEP_10   = 10'(STEP);
  localparam logic [8:0] STEP_9    = 9'(STEP);
  // The player sprite sits at the centre of the viewport.
  localparam logic [8:0] HALF_W_9  = 9'(VIEW_W / 2);
  localparam logic [8:0] HALF_H_9  = 9'(VIEW_H / 2);
  localparam int         CNT_W     = $clog2(STEP + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP - 1);

  state_t            state_q, state_d;
  dir_t              dir_q, dir_d;
  logic [8:0]        cam_x_q, cam_x_d;
  logic [8:0]        cam_y_q, cam_y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [17:0]       addr_b_q, addr_b_d;
  logic              move_done_q, move_done_d;
  logic              move_ok_q, move_ok_d;
  logic              busy_q, busy_d;

  dir_t              req_dir;
  logic              dest_ok;
  logic [9:0]        cam_x_ext, cam_y_ext;
  logic [8:0]        probe_x, probe_y;

  // -------------------------------------------------------------------------
  // Request evaluation: bounds of the destination camera and the map tile
  // the player would step onto, both derived from the live move_dir.
  // -------------------------------------------------------------------------
  always_comb begin
    req_dir   = dir_t'(move_dir);
    cam_x_ext = {1'b0, cam_x_q};
    cam_y_ext = {1'b0, cam_y_q};
    probe_x   = cam_x_q + HALF_W_9;
    probe_y   = cam_y_q + HALF_H_9;
    dest_ok   = 1'b0;
    case (req_dir)
      DIR_UP: begin
        dest_ok = cam_y_ext >= STEP_10;
        probe_y = cam_y_q + HALF_H_9 - STEP_9;
      end
      DIR_DOWN: begin
        dest_ok = (cam_y_ext + STEP_10) <= CAM_Y_MAX;
        probe_y = cam_y_q + HALF_H_9 + STEP_9;
      end
      DIR_LEFT: begin
        dest_ok = cam_x_ext >= STEP_10;
        probe_x = cam_x_q + HALF_W_9 - STEP_9;
      end
      DIR_RIGHT: begin
        dest_ok = (cam_x_ext + STEP_10) <= CAM_X_MAX;
        probe_x = cam_x_q + HALF_W_9 + STEP_9;
      end
      default: dest_ok = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Move controller next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cam_x_d   = cam_x_q;
    cam_y_d   = cam_y_q;
    cnt_d     = cnt_q;
    addr_b_d  = addr_b_q;
    move_ok_d = move_ok_q;

    case (state_q)
      ST_IDLE: begin
        if (move_req) begin
          dir_d = req_dir;
          if (dest_ok) begin
            // The probe address is loaded on entry to PROBE so the ROM
            // returns the tile by the time CHECK looks at rom_q_b.
            addr_b_d = {probe_y, probe_x};
            state_d  = ST_PROBE;
          end else begin
            move_ok_d = 1'b0;
            state_d   = ST_DONE;
          end
        end
      end

      ST_PROBE: state_d = ST_CHECK;

      ST_CHECK: begin
        if (rom_q_b == WALL_IDX) begin
          move_ok_d = 1'b0;
          state_d   = ST_DONE;
        end else begin
          cnt_d   = '0;
          state_d = ST_SCROLL;
        end
      end

      ST_SCROLL: begin
        // Camera moves only at vertical blank so no frame shows a tear.
        if (frame_tick) begin
          case (dir_q)
            DIR_UP:    cam_y_d = cam_y_q - 9'd1;
            DIR_DOWN:  cam_y_d = cam_y_q + 9'd1;
            DIR_LEFT:  cam_x_d = cam_x_q - 9'd1;
            DIR_RIGHT: cam_x_d = cam_x_q + 9'd1;
            default:   cam_x_d = cam_x_q;
          endcase
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            move_ok_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered straight from the next state.
    move_done_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_UP;
      cam_x_q     <= '0;
      cam_y_q     <= '0;
      cnt_q       <= '0;
      addr_b_q    <= '0;
      move_done_q <= 1'b0;
      move_ok_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cam_x_q     <= cam_x_d;
      cam_y_q     <= cam_y_d;
      cnt_q       <= cnt_d;
      addr_b_q    <= addr_b_d;
      move_done_q <= move_done_d;
      move_ok_q   <= move_ok_d;
      busy_q      <= busy_d;
    end
  end

  assign move_done     = move_done_q;
  assign move_ok       = move_ok_q;
  assign busy          = busy_q;
  assign rom_address_b = addr_b_q;
  assign cam_x         = cam_x_q;
  assign cam_y         = cam_y_q;

  bg_pixel_pipe u_pixel_pipe (
    .vga_clk       (vga_clk),
    .Reset         (Reset),
    .cam_x         (cam_x_q),
    .cam_y         (cam_y_q),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .rom_q_a       (rom_q_a),
    .rom_address_a (rom_address_a),
    .red           (red),
    .green         (green),
    .blue          (blue)
  );

endmodule
